// File: rtl/adder_sweep_checker_if.sv
// Operand/result bus between the sweep checker and the adder under test.
// The checker drives the operands and the adder returns sum and carry.
interface adder_sweep_checker_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] ina;
  logic [WIDTH-1:0] inb;
  logic [WIDTH-1:0] dut_result;
  logic             dut_cout;

  modport master (
    output ina,
    output inb,
    input  dut_result,
    input  dut_cout
  );

  modport slave (
    input  ina,
    input  inb,
    output dut_result,
    output dut_cout
  );
endinterface

// File: rtl/adder_sweep_checker.sv
// Exhaustive operand sweep for a WIDTH-bit adder under test.
// Counts mismatches and latches the first failing vector.
module adder_sweep_checker #(
  parameter int WIDTH        = 8,
  parameter int SETTLE       = 0,
  parameter int STOP_ON_FAIL = 0,
  parameter int ERRW         = 16
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start,
  adder_sweep_checker_if.master dut_if,
  output logic                  busy,
  output logic                  done,
  output logic                  pass,
  output logic                  fail,
  output logic [WIDTH-1:0]      fail_ina,
  output logic [WIDTH-1:0]      fail_inb,
  output logic [WIDTH-1:0]      fail_result,
  output logic                  fail_cout,
  output logic [ERRW-1:0]       err_count
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int         VW       = 2 * WIDTH;
  localparam logic [3:0] SETTLE_C = 4'(SETTLE);
  localparam logic       SOF      = (STOP_ON_FAIL != 0);

  state_t           state_q, state_d;
  logic [VW-1:0]    vec_q, vec_d;
  logic [3:0]       settle_q, settle_d;
  logic [ERRW-1:0]  err_q, err_d;
  logic             fail_q, fail_d;
  logic [WIDTH-1:0] fina_q, fina_d;
  logic [WIDTH-1:0] finb_q, finb_d;
  logic [WIDTH-1:0] fres_q, fres_d;
  logic             fcout_q, fcout_d;

  logic [WIDTH:0]   exp_sum;
  logic             cmp;
  logic             mism;
  logic             stop;

  assign dut_if.ina = vec_q[VW-1:WIDTH];
  assign dut_if.inb = vec_q[WIDTH-1:0];

  always_comb begin
    exp_sum = {1'b0, dut_if.ina} + {1'b0, dut_if.inb};
    cmp     = (state_q == RUN) && (settle_q == SETTLE_C);
    mism    = cmp &&
              ({dut_if.dut_cout, dut_if.dut_result} != exp_sum);
    stop    = cmp && ((&vec_q) || (SOF && mism));
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q  <= IDLE;
      vec_q    <= '0;
      settle_q <= '0;
      err_q    <= '0;
      fail_q   <= 1'b0;
      fina_q   <= '0;
      finb_q   <= '0;
      fres_q   <= '0;
      fcout_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      vec_q    <= vec_d;
      settle_q <= settle_d;
      err_q    <= err_d;
      fail_q   <= fail_d;
      fina_q   <= fina_d;
      finb_q   <= finb_d;
      fres_q   <= fres_d;
      fcout_q  <= fcout_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start) state_d = RUN;
      DONE:    if (start) state_d = RUN;
      RUN:     if (stop)  state_d = DONE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    vec_d    = vec_q;
    settle_d = settle_q;
    err_d    = err_q;
    fail_d   = fail_q;
    fina_d   = fina_q;
    finb_d   = finb_q;
    fres_d   = fres_q;
    fcout_d  = fcout_q;
    if (state_q != RUN) begin
      if (start) begin
        vec_d    = '0;
        settle_d = '0;
        err_d    = '0;
        fail_d   = 1'b0;
        fina_d   = '0;
        finb_d   = '0;
        fres_d   = '0;
        fcout_d  = 1'b0;
      end
    end else if (!cmp) begin
      settle_d = settle_q + 4'd1;
    end else begin
      settle_d = '0;
      // vec parks on the last (or first failing) vector
      if (!stop) vec_d = vec_q + VW'(1);
      if (mism) begin
        if (!(&err_q)) err_d = err_q + ERRW'(1);
        if (!fail_q) begin
          fail_d  = 1'b1;
          fina_d  = dut_if.ina;
          finb_d  = dut_if.inb;
          fres_d  = dut_if.dut_result;
          fcout_d = dut_if.dut_cout;
        end
      end
    end
  end

  always_comb begin
    busy        = (state_q == RUN);
    done        = (state_q == DONE);
    pass        = done && (err_q == '0);
    fail        = fail_q;
    fail_ina    = fina_q;
    fail_inb    = finb_q;
    fail_result = fres_q;
    fail_cout   = fcout_q;
    err_count   = err_q;
  end

endmodule

// File: tb/tb_adder_sweep_checker.sv
// Bench: three checker instances (plain, stop-on-fail, SETTLE=2)
// driven by a behavioural adder with selectable faults.
module tb_adder_sweep_checker;
  localparam int W = 4;

  typedef struct {
    int busy;
    int pass;
    int err;
    int fina;
    int finb;
    int fres;
    int fcout;
  } exp_t;

  typedef struct {
    int   mode;
    exp_t ea;
    exp_t eb;
    exp_t ec;
  } row_t;

  logic clock = 1'b0;
  logic reset = 1'b0;
  logic start = 1'b0;
  always #5 clock = ~clock;

  adder_sweep_checker_if #(.WIDTH(W)) if_a ();
  adder_sweep_checker_if #(.WIDTH(W)) if_b ();
  adder_sweep_checker_if #(.WIDTH(W)) if_c ();

  logic         busy [3];
  logic         done [3];
  logic         pass [3];
  logic         fail [3];
  logic         fcout[3];
  logic [W-1:0] fina [3];
  logic [W-1:0] finb [3];
  logic [W-1:0] fres [3];
  logic [15:0]  errc [3];

  int           mode = 0;
  logic [255:0] fmask = '0;
  logic [4:0]   fxor = 5'd1;
  logic [4:0]   reg_a = '0, reg_b = '0, reg_c = '0;
  int           bcnt[3];
  logic         clr_cnt = 1'b0;
  int           n_cmp = 0;
  int           n_bad = 0;

  adder_sweep_checker #(.WIDTH(W), .SETTLE(0), .STOP_ON_FAIL(0), .ERRW(16)) u_a (
    .clock(clock), .reset(reset), .start(start), .dut_if(if_a),
    .busy(busy[0]), .done(done[0]), .pass(pass[0]), .fail(fail[0]),
    .fail_ina(fina[0]), .fail_inb(finb[0]), .fail_result(fres[0]),
    .fail_cout(fcout[0]), .err_count(errc[0])
  );

  adder_sweep_checker #(.WIDTH(W), .SETTLE(0), .STOP_ON_FAIL(1), .ERRW(16)) u_b (
    .clock(clock), .reset(reset), .start(start), .dut_if(if_b),
    .busy(busy[1]), .done(done[1]), .pass(pass[1]), .fail(fail[1]),
    .fail_ina(fina[1]), .fail_inb(finb[1]), .fail_result(fres[1]),
    .fail_cout(fcout[1]), .err_count(errc[1])
  );

  adder_sweep_checker #(.WIDTH(W), .SETTLE(2), .STOP_ON_FAIL(0), .ERRW(16)) u_c (
    .clock(clock), .reset(reset), .start(start), .dut_if(if_c),
    .busy(busy[2]), .done(done[2]), .pass(pass[2]), .fail(fail[2]),
    .fail_ina(fina[2]), .fail_inb(finb[2]), .fail_result(fres[2]),
    .fail_cout(fcout[2]), .err_count(errc[2])
  );

  // modes: 0 good, 1 sum bit0 stuck 0, 2 random xor faults, 3 one-cycle registered
  function automatic logic [4:0] adder_fn(int m, logic [3:0] a, logic [3:0] b,
                                          logic [4:0] r, logic [255:0] fm,
                                          logic [4:0] fx);
    logic [4:0] s;
    s = {1'b0, a} + {1'b0, b};
    case (m)
      1:       return s & 5'h1E;
      2:       return fm[{a, b}] ? (s ^ fx) : s;
      3:       return r;
      default: return s;
    endcase
  endfunction

  always_comb {if_a.dut_cout, if_a.dut_result} =
    adder_fn(mode, if_a.ina, if_a.inb, reg_a, fmask, fxor);
  always_comb {if_b.dut_cout, if_b.dut_result} =
    adder_fn(mode, if_b.ina, if_b.inb, reg_b, fmask, fxor);
  always_comb {if_c.dut_cout, if_c.dut_result} =
    adder_fn(mode, if_c.ina, if_c.inb, reg_c, fmask, fxor);

  always @(posedge clock) begin
    reg_a <= {1'b0, if_a.ina} + {1'b0, if_a.inb};
    reg_b <= {1'b0, if_b.ina} + {1'b0, if_b.inb};
    reg_c <= {1'b0, if_c.ina} + {1'b0, if_c.inb};
    for (int i = 0; i < 3; i++) begin
      if (clr_cnt) bcnt[i] <= 0;
      else if (busy[i]) bcnt[i] <= bcnt[i] + 1;
    end
  end

  function automatic exp_t mk(int bz, int ps, int er, int fa, int fb,
                              int fr, int fc);
    exp_t e;
    e.busy = bz; e.pass = ps; e.err = er;
    e.fina = fa; e.finb = fb; e.fres = fr; e.fcout = fc;
    return e;
  endfunction

  // Walks every operand pair with plain arithmetic (combinational modes only)
  function automatic exp_t model(int m, bit sof, int settle,
                                 logic [255:0] fm, logic [4:0] fx);
    exp_t       e;
    int         first;
    logic [7:0] v8;
    logic [4:0] got, want;
    e = mk(0, 0, 0, 0, 0, 0, 0);
    first = -1;
    for (int v = 0; v < 256; v++) begin
      v8 = v[7:0];
      got = adder_fn(m, v8[7:4], v8[3:0], 5'd0, fm, fx);
      want = {1'b0, v8[7:4]} + {1'b0, v8[3:0]};
      if (got != want) begin
        if (first < 0) begin
          first = v;
          e.fina = int'(v8[7:4]);
          e.finb = int'(v8[3:0]);
          e.fres = int'(got[3:0]);
          e.fcout = int'(got[4]);
        end
        e.err++;
      end
    end
    if (sof && first >= 0) begin
      e.err = 1;
      e.busy = (first + 1) * (settle + 1);
    end else begin
      e.busy = 256 * (settle + 1);
    end
    e.pass = (e.err == 0) ? 1 : 0;
    return e;
  endfunction

  task automatic chk(string nm, int act, int req);
    n_cmp++;
    if (act != req) begin
      n_bad++;
      $display("FAIL %s: got %0d, required %0d", nm, act, req);
    end
  endtask

  function automatic int ina_of(int i);
    case (i)
      0:       return int'(if_a.ina);
      1:       return int'(if_b.ina);
      default: return int'(if_c.ina);
    endcase
  endfunction

  function automatic int inb_of(int i);
    case (i)
      0:       return int'(if_a.inb);
      1:       return int'(if_b.inb);
      default: return int'(if_c.inb);
    endcase
  endfunction

  task automatic check_inst(string tag, int i, exp_t e);
    string p;
    p = $sformatf("%s u%0d", tag, i);
    chk({p, " busy_cycles"}, bcnt[i], e.busy);
    chk({p, " done"}, int'(done[i]), 1);
    chk({p, " busy"}, int'(busy[i]), 0);
    chk({p, " pass"}, int'(pass[i]), e.pass);
    chk({p, " fail"}, int'(fail[i]), (e.err != 0) ? 1 : 0);
    chk({p, " err_count"}, int'(errc[i]), e.err);
    chk({p, " fail_ina"}, int'(fina[i]), e.fina);
    chk({p, " fail_inb"}, int'(finb[i]), e.finb);
    chk({p, " fail_result"}, int'(fres[i]), e.fres);
    chk({p, " fail_cout"}, int'(fcout[i]), e.fcout);
    if (i != 1) begin
      chk({p, " ina_hold"}, ina_of(i), 15);
      chk({p, " inb_hold"}, inb_of(i), 15);
    end
  endtask

  task automatic do_reset();
    reset = 1'b0;
    clr_cnt = 1'b1;
    @(negedge clock);
    reset = 1'b1;
    clr_cnt = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
  endtask

  task automatic wait_done(string tag, int budget);
    int k;
    k = 0;
    while (!(done[0] && done[1] && done[2]) && k < budget) begin
      @(negedge clock);
      k++;
    end
    chk({tag, " done_within_budget"},
        (done[0] && done[1] && done[2]) ? 1 : 0, 1);
  endtask

  task automatic run_row(string tag, row_t r);
    mode = r.mode;
    do_reset();
    pulse_start();
    wait_done(tag, 1200);
    check_inst(tag, 0, r.ea);
    check_inst(tag, 1, r.eb);
    check_inst(tag, 2, r.ec);
  endtask

  task automatic check_zero(string tag);
    chk({tag, " busy"}, int'(busy[0]), 0);
    chk({tag, " done"}, int'(done[0]), 0);
    chk({tag, " pass"}, int'(pass[0]), 0);
    chk({tag, " fail"}, int'(fail[0]), 0);
    chk({tag, " err_count"}, int'(errc[0]), 0);
    chk({tag, " fail_ina"}, int'(fina[0]), 0);
    chk({tag, " fail_inb"}, int'(finb[0]), 0);
    chk({tag, " fail_result"}, int'(fres[0]), 0);
    chk({tag, " fail_cout"}, int'(fcout[0]), 0);
    chk({tag, " ina"}, int'(if_a.ina), 0);
    chk({tag, " inb"}, int'(if_a.inb), 0);
  endtask

  initial begin
    row_t rows[3];
    row_t rr;
    int   k;

    rows[0].mode = 0;
    rows[0].ea = mk(256, 1, 0, 0, 0, 0, 0);
    rows[0].eb = mk(256, 1, 0, 0, 0, 0, 0);
    rows[0].ec = mk(768, 1, 0, 0, 0, 0, 0);
    rows[1].mode = 1;
    rows[1].ea = mk(256, 0, 128, 0, 1, 0, 0);
    rows[1].eb = mk(2, 0, 1, 0, 1, 0, 0);
    rows[1].ec = mk(768, 0, 128, 0, 1, 0, 0);
    rows[2].mode = 3;
    rows[2].ea = mk(256, 0, 255, 0, 1, 0, 0);
    rows[2].eb = mk(2, 0, 1, 0, 1, 0, 0);
    rows[2].ec = mk(768, 1, 0, 0, 0, 0, 0);

    reset = 1'b0;
    clr_cnt = 1'b1;
    repeat (2) @(negedge clock);
    check_zero("reset_state");
    reset = 1'b1;
    clr_cnt = 1'b0;
    @(negedge clock);

    for (int i = 0; i < 3; i++) run_row($sformatf("row%0d", i), rows[i]);

    for (int t = 0; t < 4; t++) begin
      fmask = '0;
      k = (t == 0) ? 0 : int'($urandom_range(1, 6));
      for (int j = 0; j < k; j++) fmask[$urandom_range(0, 255)] = 1'b1;
      fxor = 5'($urandom_range(1, 31));
      rr.mode = 2;
      rr.ea = model(2, 1'b0, 0, fmask, fxor);
      rr.eb = model(2, 1'b1, 0, fmask, fxor);
      rr.ec = model(2, 1'b0, 2, fmask, fxor);
      run_row($sformatf("rand%0d", t), rr);
    end

    // reset dropped in the middle of a failing sweep
    mode = 1;
    do_reset();
    pulse_start();
    k = 0;
    while ({if_a.ina, if_a.inb} != 8'd100 && k < 400) begin
      @(negedge clock);
      k++;
    end
    chk("midreset reached_vec100", int'({if_a.ina, if_a.inb}), 100);
    chk("midreset fail_before", int'(fail[0]), 1);
    reset = 1'b0;
    @(negedge clock);
    reset = 1'b1;
    check_zero("midreset");
    clr_cnt = 1'b1;
    @(negedge clock);
    clr_cnt = 1'b0;
    pulse_start();
    chk("restart busy", int'(busy[0]), 1);
    chk("restart ina", int'(if_a.ina), 0);
    chk("restart inb", int'(if_a.inb), 0);
    wait_done("restart", 1200);
    check_inst("restart", 0, mk(256, 0, 128, 0, 1, 0, 0));

    // start held during RUN is ignored; start in DONE restarts clean
    mode = 1;
    do_reset();
    pulse_start();
    repeat (50) @(negedge clock);
    start = 1'b1;
    repeat (3) @(negedge clock);
    start = 1'b0;
    wait_done("ignore", 1200);
    check_inst("ignore", 0, mk(256, 0, 128, 0, 1, 0, 0));
    mode = 0;
    clr_cnt = 1'b1;
    start = 1'b1;
    @(negedge clock);
    clr_cnt = 1'b0;
    start = 1'b0;
    chk("redo done", int'(done[0]), 0);
    chk("redo busy", int'(busy[0]), 1);
    chk("redo err_count", int'(errc[0]), 0);
    chk("redo fail", int'(fail[0]), 0);
    chk("redo fail_inb", int'(finb[0]), 0);
    chk("redo ina", int'(if_a.ina), 0);
    chk("redo inb", int'(if_a.inb), 0);
    wait_done("redo", 1200);
    check_inst("redo", 0, mk(256, 1, 0, 0, 0, 0, 0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
